// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin/lockable two-port arbiter in front of a single-port word memory,
// with address checking and a registered one-cycle response per grant.
module dmem_arbiter #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_MemWrite,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        gnt, bad, good, we;
  logic [31:0] addr, rsp_data;
  always_comb begin
    m0_gnt = !rst && m0_req && (state_q == LOCK0 || (state_q == ARB && (!m1_req || last_q)));
    m1_gnt = !rst && m1_req && (state_q == LOCK1 || (state_q == ARB && (!m0_req || !last_q)));
    gnt = m0_gnt || m1_gnt;
    addr = m1_gnt ? m1_addr : m0_addr;
    we = m1_gnt ? m1_we : m0_we;
    bad = addr[1:0] != 2'b00 || {2'b00, addr[31:2]} >= 32'(DEPTH);
    good = gnt && !bad;
    // bad accesses never reach the memory pins, so an out-of-range index cannot alias
    mem_address = good ? {2'b00, addr[31:2]} : '0;
    mem_write_data = good ? (m1_gnt ? m1_wdata : m0_wdata) : '0;
    mem_MemWrite = good && we;
    rsp_data = (good && !we) ? mem_read_data : '0;
    state_d = (m0_gnt && m0_lock) ? LOCK0 : (m1_gnt && m1_lock) ? LOCK1 : ARB;
    last_d = gnt ? m1_gnt : last_q;
    rvalid0_d = m0_gnt;
    rvalid1_d = m1_gnt;
    rdata0_d = m0_gnt ? rsp_data : '0;
    rdata1_d = m1_gnt ? rsp_data : '0;
    err0_d = m0_gnt && bad;
    err1_d = m1_gnt && bad;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      last_q <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
    end
  end
  // responses are masked while rst is high so a pending pulse never escapes
  always_comb begin
    m0_rvalid = rvalid0_q && !rst;
    m1_rvalid = rvalid1_q && !rst;
    m0_rdata = rst ? '0 : rdata0_q;
    m1_rdata = rst ? '0 : rdata1_q;
    m0_err = err0_q && !rst;
    m1_err = err1_q && !rst;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table for the planned scenarios, then random traffic
// checked against a transaction-level model of the arbiter and memory.
module tb_dmem_arbiter;
  localparam int DEPTH = 1024;
  logic        clk = 1'b0;
  logic        rst;
  logic        req [2];
  logic        we [2];
  logic        lk [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic        gnt [2];
  logic        rv [2];
  logic [31:0] rd [2];
  logic        er [2];
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_MemWrite;
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lk[0]), .m0_addr(ad[0]), .m0_wdata(wd[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lk[1]), .m1_addr(ad[1]), .m1_wdata(wd[1]),
    .m0_gnt(gnt[0]), .m0_rvalid(rv[0]), .m0_rdata(rd[0]), .m0_err(er[0]),
    .m1_gnt(gnt[1]), .m1_rvalid(rv[1]), .m1_rdata(rd[1]), .m1_err(er[1]),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_MemWrite(mem_MemWrite), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[9:0]];

  typedef struct {
    logic rs;
    logic r0, w0, l0; logic [31:0] a0, d0;
    logic r1, w1, l1; logic [31:0] a1, d1;
    logic g0, g1, mw; logic [31:0] ma; logic dc;
    logic v0, v1; logic [31:0] rdv; logic erv;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t V(input logic rs, r0, w0, l0, input logic [31:0] a0, d0,
                             input logic r1, w1, l1, input logic [31:0] a1, d1,
                             input logic g0, g1, mw, input logic [31:0] ma, input logic dc,
                             input logic v0, v1, input logic [31:0] rdv, input logic erv);
    vec_t v;
    v.rs = rs; v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.mw = mw; v.ma = ma; v.dc = dc;
    v.v0 = v0; v.v1 = v1; v.rdv = rdv; v.erv = erv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // memory write lands just after the edge, using pin values sampled mid-cycle
  task automatic edge_and_write();
    logic        w;
    logic [31:0] a, d;
    w = mem_MemWrite; a = mem_address; d = mem_write_data;
    @(posedge clk);
    #1;
    if (w) mem[a[9:0]] = d;
  endtask

  task automatic new_req(input int p);
    int r;
    req[p] = $urandom_range(0, 3) != 0;
    we[p] = 1'($urandom_range(0, 1));
    lk[p] = $urandom_range(0, 3) == 0;
    wd[p] = $urandom;
    r = int'($urandom_range(0, 9));
    if (r == 0) ad[p] = 32'(($urandom_range(0, 15) << 2) | $urandom_range(1, 3));
    else if (r == 1) ad[p] = 32'((DEPTH + $urandom_range(0, 7)) << 2);
    else if (r == 2) ad[p] = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
    else ad[p] = 32'($urandom_range(0, 15) << 2);
  endtask

  initial begin
    vec_t v;
    int owner, last, gp;
    logic bad, good, hold [2];
    logic pv [2], per [2];
    logic [31:0] prd [2];
    logic [31:0] A4;
    A4 = 32'hA000_0004;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = 0; lk[p] = 0; ad[p] = 0; wd[p] = 0;
    end
    @(posedge clk);
    #1;
    // rs r0 w0 l0 a0 d0 | r1 w1 l1 a1 d1 | g0 g1 mw ma dc | v0 v1 rdata err
    tbl.push_back(V(1, 1,0,0,'h10,0, 1,0,0,'h10,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(V(0, 1,0,0,'h10,0, 1,0,0,'h10,0, 1,0,0,4,0, 0,0,0,0));
    tbl.push_back(V(0, 1,0,0,'h10,0, 1,0,0,'h10,0, 0,1,0,4,0, 1,0,A4,0));
    tbl.push_back(V(0, 1,0,0,'h10,0, 1,0,0,'h10,0, 1,0,0,4,0, 0,1,A4,0));
    tbl.push_back(V(0, 1,0,0,'h10,0, 1,0,0,'h10,0, 0,1,0,4,0, 1,0,A4,0));
    tbl.push_back(V(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,1,A4,0));
    tbl.push_back(V(0, 1,1,0,'h20,'hDEADBEEF, 0,0,0,0,0, 1,0,1,8,0, 0,0,0,0));
    tbl.push_back(V(0, 1,0,0,'h20,0, 0,0,0,0,0, 1,0,0,8,0, 1,0,0,0));
    tbl.push_back(V(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 1,0,'hDEADBEEF,0));
    tbl.push_back(V(0, 0,0,0,0,0, 1,1,0,'h22,'h1111_1111, 0,1,0,0,1, 0,0,0,0));
    tbl.push_back(V(0, 0,0,0,0,0, 1,1,0,'h1000,'h2222_2222, 0,1,0,0,1, 0,1,0,1));
    tbl.push_back(V(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,1,0,1));
    tbl.push_back(V(0, 1,0,0,'h10,0, 0,0,0,0,0, 1,0,0,4,0, 0,0,0,0));
    tbl.push_back(V(0, 1,0,0,'h10,0, 1,1,1,'h0,'hB0, 0,1,1,0,0, 1,0,A4,0));
    tbl.push_back(V(0, 1,0,0,'h10,0, 1,1,1,'h4,'hB1, 0,1,1,1,0, 0,1,0,0));
    tbl.push_back(V(0, 1,0,0,'h10,0, 1,1,1,'h8,'hB2, 0,1,1,2,0, 0,1,0,0));
    tbl.push_back(V(0, 1,0,0,'h10,0, 1,1,0,'hC,'hB3, 0,1,1,3,0, 0,1,0,0));
    tbl.push_back(V(0, 1,0,0,'h10,0, 1,0,0,'h0,0, 1,0,0,4,0, 0,1,0,0));
    tbl.push_back(V(0, 0,0,0,0,0, 1,0,0,'h0,0, 0,1,0,0,0, 1,0,A4,0));
    tbl.push_back(V(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,1,'hB0,0));
    tbl.push_back(V(0, 1,0,0,'h4,0, 1,0,0,'h8,0, 1,0,0,1,0, 0,0,0,0));
    tbl.push_back(V(1, 1,0,0,'h4,0, 1,0,0,'h8,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(V(0, 1,0,0,'h4,0, 1,0,0,'h8,0, 1,0,0,1,0, 0,0,0,0));
    tbl.push_back(V(0, 0,0,0,0,0, 1,0,0,'h8,0, 0,1,0,2,0, 1,0,'hB1,0));
    tbl.push_back(V(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,1,'hB2,0));
    tbl.push_back(V(0, 1,0,1,'h10,0, 0,0,0,0,0, 1,0,0,4,0, 0,0,0,0));
    tbl.push_back(V(0, 0,0,0,0,0, 1,0,0,'h10,0, 0,0,0,0,0, 1,0,A4,0));
    tbl.push_back(V(0, 0,0,0,0,0, 1,0,0,'h10,0, 0,1,0,4,0, 0,0,0,0));
    tbl.push_back(V(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,1,A4,0));
    foreach (tbl[i]) begin
      v = tbl[i];
      rst = v.rs;
      req[0] = v.r0; we[0] = v.w0; lk[0] = v.l0; ad[0] = v.a0; wd[0] = v.d0;
      req[1] = v.r1; we[1] = v.w1; lk[1] = v.l1; ad[1] = v.a1; wd[1] = v.d1;
      @(negedge clk);
      chk($sformatf("row%0d gnt0", i), 32'(gnt[0]), 32'(v.g0));
      chk($sformatf("row%0d gnt1", i), 32'(gnt[1]), 32'(v.g1));
      chk($sformatf("row%0d memwrite", i), 32'(mem_MemWrite), 32'(v.mw));
      if (!v.dc) chk($sformatf("row%0d mem_address", i), mem_address, v.ma);
      chk($sformatf("row%0d rvalid0", i), 32'(rv[0]), 32'(v.v0));
      chk($sformatf("row%0d rvalid1", i), 32'(rv[1]), 32'(v.v1));
      chk($sformatf("row%0d rdata0", i), rd[0], v.v0 ? v.rdv : 32'h0);
      chk($sformatf("row%0d rdata1", i), rd[1], v.v1 ? v.rdv : 32'h0);
      chk($sformatf("row%0d err0", i), 32'(er[0]), 32'(v.v0 && v.erv));
      chk($sformatf("row%0d err1", i), 32'(er[1]), 32'(v.v1 && v.erv));
      edge_and_write();
      if (i == 11) begin
        chk("bad write kept word8", mem[8], 32'hDEADBEEF);
        chk("bad write kept word0", mem[0], 32'hA000_0000);
      end
    end
    // random phase: model tracks owner (-1 = free), last grant and its own memory image
    rst = 1'b1;
    req[0] = 0; req[1] = 0;
    edge_and_write();
    rst = 1'b0;
    foreach (mem[i]) ref_mem[i] = mem[i];
    owner = -1; last = 1;
    pv[0] = 0; pv[1] = 0; per[0] = 0; per[1] = 0; prd[0] = 0; prd[1] = 0;
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p] || $urandom_range(0, 15) == 0) new_req(p);
      end
      rst = $urandom_range(0, 49) == 0;
      gp = -1;
      if (!rst) begin
        if (req[0] && (owner < 0 || owner == 0) && req[1] && (owner < 0 || owner == 1)) gp = 1 - last;
        else if (req[0] && (owner < 0 || owner == 0)) gp = 0;
        else if (req[1] && (owner < 0 || owner == 1)) gp = 1;
      end
      bad = gp >= 0 && (ad[gp][1:0] != 2'b00 || (ad[gp] >> 2) >= 32'(DEPTH));
      good = gp >= 0 && !bad;
      @(negedge clk);
      chk($sformatf("rnd%0d gnt0", c), 32'(gnt[0]), 32'(gp == 0));
      chk($sformatf("rnd%0d gnt1", c), 32'(gnt[1]), 32'(gp == 1));
      chk($sformatf("rnd%0d memwrite", c), 32'(mem_MemWrite), 32'(good && we[gp]));
      chk($sformatf("rnd%0d mem_address", c), mem_address, good ? ad[gp] >> 2 : 32'h0);
      chk($sformatf("rnd%0d mem_wdata", c), mem_write_data, good ? wd[gp] : 32'h0);
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rnd%0d rvalid%0d", c, p), 32'(rv[p]), 32'(pv[p] && !rst));
        chk($sformatf("rnd%0d rdata%0d", c, p), rd[p], rst ? 32'h0 : prd[p]);
        chk($sformatf("rnd%0d err%0d", c, p), 32'(er[p]), 32'(per[p] && !rst));
      end
      for (int p = 0; p < 2; p++) begin
        pv[p] = !rst && gp == p;
        per[p] = !rst && gp == p && bad;
        prd[p] = (!rst && gp == p && good && !we[p]) ? ref_mem[ad[p][11:2]] : 32'h0;
        hold[p] = req[p] && gp != p;
      end
      if (good && we[gp]) ref_mem[ad[gp][11:2]] = wd[gp];
      if (rst) begin
        owner = -1; last = 1;
      end else begin
        owner = (gp >= 0 && lk[gp]) ? gp : -1;
        if (gp >= 0) last = gp;
      end
      edge_and_write();
    end
    for (int i = 0; i < 16; i++) chk($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
